// File: rtl/ofm_writeback_buffer.sv
// ofm_writeback_buffer
//   Buffers lane-muxed OFM words from the 1x1 data controller, applies optional
//   per-lane ReLU on entry, and drains them into the next-layer IFM RAM through
//   a ready/valid write port with linearly incrementing addresses.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 arms a new layer; honoured only in IDLE/DONE
//   base_addr             first RAM address, sampled on start
//   total_words           words expected for the layer, sampled on start
//   in_valid, in_data     word strobe and muxed OFM word from the controller
//   done_in               upstream compute finished (level)
//   ram_ready             RAM accepts the write this cycle
//   ram_wr_en, ram_addr,
//   ram_wr_data           write request, address and data (held while stalled)
//   busy, done            status: RUN/DRAIN, and DONE until the next start
//   overflow              sticky: a word was dropped on a full FIFO
//   word_count            words written since start
module ofm_writeback_buffer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [31:0]               total_words,
  input  logic                      in_valid,
  input  logic [DATA_W*LANES-1:0]   in_data,
  input  logic                      done_in,
  input  logic                      ram_ready,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W*LANES-1:0]   ram_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [31:0]               word_count
);

  localparam int unsigned WORD_W = DATA_W * LANES;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fill_q;
  logic [ADDR_W-1:0]   addr_ptr_q;
  logic [31:0]         word_count_q;
  logic [31:0]         total_q;
  logic                overflow_q;

  logic active_c, start_ok_c, empty_c, full_c, pop_c, push_c, drop_c;

  // Clamp negative lanes to zero when ReLU is enabled.
  function automatic logic [WORD_W-1:0] relu(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    if (RELU_EN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w[i*DATA_W + DATA_W - 1]) r[i*DATA_W +: DATA_W] = '0;
      end
    end
    return r;
  endfunction

  // FIFO handshake decode; a full FIFO still takes a push when it pops the same cycle.
  always_comb begin
    active_c   = (state_q == S_RUN) || (state_q == S_DRAIN);
    start_ok_c = start && !active_c;
    empty_c    = (fill_q == '0);
    full_c     = (fill_q == CNT_W'(FIFO_DEPTH));
    pop_c      = active_c && !empty_c && ram_ready;
    push_c     = active_c && in_valid && (!full_c || pop_c);
    drop_c     = active_c && in_valid && full_c && !pop_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DRAIN waits until no word is left or arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (done_in || (word_count_q == total_q)) state_d = S_DRAIN;
      S_DRAIN: if (empty_c && !push_c) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state and FIFO head.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;
    busy        = active_c;
    done        = (state_q == S_DONE);
    ram_wr_en   = active_c && !empty_c;
    if (ram_wr_en) ram_wr_data = mem_q[rd_ptr_q];
  end

  assign ram_addr   = addr_ptr_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

  // Pointers, fill level, address and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      addr_ptr_q   <= '0;
      word_count_q <= '0;
      total_q      <= '0;
      overflow_q   <= 1'b0;
    end else if (start_ok_c) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      addr_ptr_q   <= base_addr;
      word_count_q <= '0;
      total_q      <= total_words;
      overflow_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        addr_ptr_q   <= addr_ptr_q + ADDR_W'(1);
        word_count_q <= word_count_q + 32'd1;
      end
      case ({push_c, pop_c})
        2'b10:   fill_q <= fill_q + CNT_W'(1);
        2'b01:   fill_q <= fill_q - CNT_W'(1);
        default: fill_q <= fill_q;
      endcase
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  // Storage array; contents are only meaningful below the fill level.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= relu(in_data);
  end

endmodule
